// File: rtl/pcm_rec_play_ctrl_if.sv
// Sample FIFO handshake between the record/playback controller and the FIFO.
interface pcm_rec_play_ctrl_if;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_dout;
  logic fifo_wr;
  logic fifo_rd;
  logic fifo_din;

  // Controller side
  modport master (
    output fifo_wr,
    output fifo_rd,
    output fifo_din,
    input  fifo_full,
    input  fifo_empty,
    input  fifo_dout
  );

  // FIFO side
  modport slave (
    input  fifo_wr,
    input  fifo_rd,
    input  fifo_din,
    output fifo_full,
    output fifo_empty,
    output fifo_dout
  );
endinterface

// File: rtl/pcm_rec_play_ctrl.sv
// PDM record/playback controller: records microphone bits into a FIFO once per
// sample tick and replays them from the FIFO, with a free-running tick divider.
module pcm_rec_play_ctrl #(
  parameter int unsigned DIV         = 25,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_SAMPLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 btn_rec_i,
  input  logic                 btn_play_i,
  input  logic                 mic_data_i,
  output logic                 mic_clk_o,
  output logic                 audio_out_o,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     sample_cnt_o,
  pcm_rec_play_ctrl_if.master  fifo
);

  localparam int unsigned DivW = $clog2(DIV);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_SAMPLES);
  // Cycles from the read strobe to the audio latch
  localparam logic [2:0] ReadWait = 3'd4;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRecord = 2'b01,
    StPlay   = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q;
  logic              tick;
  logic              rec_q, play_q, arm_q;
  logic              rec_edge, play_edge;
  logic              fifo_wr_q, fifo_rd_q, fifo_din_q;
  logic              audio_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        wait_q;
  logic              wr_set, rd_set, cnt_clr, play_abort;

  // Free-running sample divider; tick on count 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DivW'(DIV - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick      = (div_q == '0);
  assign mic_clk_o = (div_q < DivW'(DIV / 2));

  // Button edge registers; arm_q masks a level already high at reset release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rec_q  <= 1'b0;
      play_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      rec_q  <= btn_rec_i;
      play_q <= btn_play_i;
      arm_q  <= 1'b1;
    end
  end

  assign rec_edge  = arm_q & btn_rec_i & ~rec_q;
  assign play_edge = arm_q & btn_play_i & ~play_q;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        // rec takes priority when both edges arrive together
        if (rec_edge && !fifo.fifo_full) begin
          state_d = StRecord;
        end else if (play_edge && !fifo.fifo_empty) begin
          state_d = StPlay;
        end
      end
      StRecord: begin
        if (rec_edge || (cnt_q >= MaxCnt) || (tick && fifo.fifo_full)) begin
          state_d = StIdle;
        end
      end
      StPlay: begin
        if (play_edge || (tick && fifo.fifo_empty)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: strobe requests, counter clear and playback abort
  always_comb begin
    wr_set     = 1'b0;
    rd_set     = 1'b0;
    cnt_clr    = 1'b0;
    play_abort = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_clr = (state_d == StRecord);
      end
      StRecord: begin
        wr_set = (state_d == StRecord) && tick && !fifo.fifo_full && (cnt_q < MaxCnt);
      end
      StPlay: begin
        rd_set     = (state_d == StPlay) && tick && !fifo.fifo_empty;
        play_abort = (state_d == StIdle);
      end
      default: ;
    endcase
  end

  // Strobes, write data and sample counter; strobes only fire on a tick, so
  // they are spaced DIV cycles apart and fifo_din is stable until the next write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_din_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      fifo_wr_q <= wr_set;
      fifo_rd_q <= rd_set;
      if (wr_set) begin
        fifo_din_q <= mic_data_i;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (wr_set) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Delayed capture of FIFO read data into the audio output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q  <= '0;
      audio_q <= 1'b0;
    end else if (play_abort) begin
      wait_q  <= '0;
      audio_q <= 1'b0;
    end else begin
      if (rd_set) begin
        wait_q <= ReadWait;
      end else if (wait_q != '0) begin
        wait_q <= wait_q - 1'b1;
      end
      if (wait_q == 3'd1) begin
        audio_q <= fifo.fifo_dout;
      end
    end
  end

  assign fifo.fifo_wr  = fifo_wr_q;
  assign fifo.fifo_rd  = fifo_rd_q;
  assign fifo.fifo_din = fifo_din_q;
  assign audio_out_o   = audio_q;
  assign state_o       = state_q;
  assign sample_cnt_o  = cnt_q;

endmodule

// File: doc/pcm_rec_play_ctrl.md
PCM_REC_PLAY_CTRL -- requirements
Module: pcm_rec_play_ctrl

Interface
REQ-001 Parameter DIV, default 25, system-clock cycles per sample tick; legal range 8..65535.
REQ-002 Parameter CNT_W, default 16, width of the sample counter.
REQ-003 Parameter MAX_SAMPLES, default 65535, record length limit in samples; must be at least 1 and at most 2**CNT_W-1.
REQ-004 clock  in  1  system clock; all logic is rising-edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 btn_rec  in  1  record request level, already synchronised and debounced.
REQ-007 btn_play  in  1  playback request level, already synchronised and debounced.
REQ-008 mic_data  in  1  PDM bit from the microphone.
REQ-009 fifo_full, fifo_empty  in  1 each  flags from the sample FIFO.
REQ-010 fifo_dout  in  1  FIFO read data.
REQ-011 mic_clk  out  1  microphone clock, one period per tick.
REQ-012 fifo_wr, fifo_rd  out  1 each  FIFO strobes; each is a one-cycle pulse.
REQ-013 fifo_din  out  1  FIFO write data.
REQ-014 audio_out  out  1  replayed PDM bit.
REQ-015 state  out  2  state code: 00 IDLE, 01 RECORD, 10 PLAY, 11 not used.
REQ-016 sample_cnt  out  CNT_W  count of samples written in the current or last recording.

Function
REQ-017 Divider counts 0..DIV-1 and wraps to 0; tick is high for one cycle when the count is 0.
REQ-018 mic_clk is high while the divider count is below DIV/2 (integer division), and low otherwise.
REQ-019 Button edge is a registered 0->1 transition of the level; each edge is seen for exactly one cycle.
REQ-020 IDLE: a rec edge with fifo_full=0 goes to RECORD and clears sample_cnt to 0; a rec edge with fifo_full=1 is ignored.
REQ-021 IDLE: a play edge with fifo_empty=0 goes to PLAY; a play edge with fifo_empty=1 is ignored.
REQ-022 IDLE: rec and play edges in the same cycle go to RECORD; rec wins.
REQ-023 RECORD, on tick with fifo_full=0 and sample_cnt<MAX_SAMPLES: register mic_data into fifo_din, pulse fifo_wr for 1 cycle, and increment sample_cnt.
REQ-024 fifo_din holds its value for at least 4 cycles after the fifo_wr pulse, to cover the FIFO's falling-edge detect latency.
REQ-025 RECORD goes to IDLE on any of: a rec edge; a tick with fifo_full=1; sample_cnt reaching MAX_SAMPLES. No pulse is issued on the exit cycle.
REQ-026 RECORD ignores play edges.
REQ-027 PLAY, on tick with fifo_empty=0: pulse fifo_rd for 1 cycle, wait 4 cycles, then latch fifo_dout into audio_out.
REQ-028 PLAY, on tick with fifo_empty=1: go to IDLE and clear audio_out to 0.
REQ-029 A play edge in PLAY goes to IDLE immediately; any pending latch is abandoned and audio_out clears to 0.
REQ-030 PLAY ignores rec edges.
REQ-031 fifo_wr and fifo_rd are never high in the same cycle.
REQ-032 No second strobe is issued until at least 8 cycles after the previous one.
REQ-033 sample_cnt saturates at MAX_SAMPLES and does not wrap.
REQ-034 sample_cnt holds its value in IDLE and PLAY.
REQ-035 The divider runs freely in every state; mic_clk toggles in IDLE too.

Reset
REQ-036 While reset=1: state=00, divider=0, mic_clk=1, fifo_wr=0, fifo_rd=0, fifo_din=0, audio_out=0, sample_cnt=0, edge registers=0.
REQ-037 A reset asserted during RECORD or PLAY aborts at once; no strobe is issued in the cycle after release.
REQ-038 A button already held high when reset releases does not create an edge.

Verification (DIV=8, MAX_SAMPLES=5)
REQ-039 Rec edge, fifo_full=0, mic_data alternating 1,0 per tick -> exactly 5 fifo_wr pulses 8 cycles apart; fifo_din = 1,0,1,0,1; sample_cnt=5; state returns to 00.
REQ-040 RECORD with fifo_full rising after the 2nd write -> next tick gives no pulse, state=00, sample_cnt=2.
REQ-041 FIFO model preloaded with bits 1,1,0, then play edge -> 3 fifo_rd pulses; audio_out = 1,1,0, each 4 cycles after its pulse; on the 4th tick fifo_empty=1, so state=00 and audio_out=0.
REQ-042 In IDLE, rec and play edges in the same cycle -> state=01 and no fifo_rd pulse.
REQ-043 Reset asserted 2 cycles after a fifo_rd pulse -> audio_out stays 0, all outputs take reset values, state=00.
REQ-044 Play edge with fifo_empty=1 -> state stays 00 and no strobe is issued.
